// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO scheduler, its select-code consumers and the output mux.
// Select code: bit 7 = valid, bits [6:0] = port index, all-zero = no FIFO chosen.
package fifo_sched_pkg;

    localparam logic [7:0]  NON_FIFO_CHOOSE  = 8'd0;
    localparam int unsigned CHOOSE_VALID_BIT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } sched_state_e;

    function automatic logic [7:0] build_sel_code(input logic [6:0] idx);
        logic [7:0] code;
        code                   = {1'b0, idx};
        code[CHOOSE_VALID_BIT] = 1'b1;
        return code;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after start, wrapping at PORT_NUM.
// Rotates the request vector down by start, priority-encodes, then rotates the index back.
module rr_pick #(
    parameter int unsigned PORT_NUM = 14,
    parameter int unsigned IDX_W    = $clog2(PORT_NUM)
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [IDX_W-1:0]    start,
    output logic                found,
    output logic [IDX_W-1:0]    index
);

    localparam logic [IDX_W:0] PORTS = (IDX_W + 1)'(PORT_NUM);

    logic [PORT_NUM-1:0] rotated;
    logic [IDX_W-1:0]    off;
    logic [IDX_W:0]      sum;

    always_comb begin
        rotated = PORT_NUM'({req, req} >> start);
        found   = |req;
        off     = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            if (rotated[i]) off = IDX_W'(i);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= PORTS) sum = sum - PORTS;
        index = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// Packet-level round-robin scheduler: grants one non-empty ingress FIFO until its eop word
// is popped (or the word watchdog fires), driving pop strobes and the registered select code.
module fifo_rr_sched
    import fifo_sched_pkg::*;
#(
    parameter int unsigned PORT_NUM      = 14,
    parameter int unsigned MAX_PKT_WORDS = 256
) (
    input  logic                glb_clk,
    input  logic                glb_areset_n,
    input  logic [PORT_NUM-1:0] fifo_req_bits,
    input  logic [PORT_NUM-1:0] fifo_eop_bits,
    input  logic                out_ready,
    output logic [PORT_NUM-1:0] fifo_rd_en,
    output logic [7:0]          fifo_sel_res_final,
    output logic                out_valid,
    output logic                sched_busy,
    output logic                timeout_err
);

    localparam int unsigned     IDX_W    = $clog2(PORT_NUM);
    localparam int unsigned     CNT_W    = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_NUM - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT_WORDS);

    sched_state_e     state_q;
    logic [IDX_W-1:0] sel_idx_q, last_grant_q;
    logic [CNT_W-1:0] word_cnt_q, cnt_inc;
    logic [7:0]       code_q;
    logic             timeout_q;

    logic [IDX_W-1:0] pick_start, pick_idx;
    logic             pick_found;
    logic             rd_hit;

    // The search starts just past the last released port, so it ranks lowest next time.
    assign pick_start = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;

    rr_pick #(
        .PORT_NUM (PORT_NUM),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .req   (fifo_req_bits),
        .start (pick_start),
        .found (pick_found),
        .index (pick_idx)
    );

    assign rd_hit  = (state_q == XFER) & out_ready & fifo_req_bits[sel_idx_q];
    assign cnt_inc = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;

    always_comb begin
        fifo_rd_en            = '0;
        fifo_rd_en[sel_idx_q] = rd_hit;
    end

    always_ff @(posedge glb_clk or negedge glb_areset_n) begin
        if (!glb_areset_n) begin
            state_q      <= IDLE;
            sel_idx_q    <= '0;
            last_grant_q <= LAST_IDX;
            word_cnt_q   <= '0;
            code_q       <= NON_FIFO_CHOOSE;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|fifo_req_bits) state_q <= GRANT;
                end
                GRANT: begin
                    if (pick_found) begin
                        sel_idx_q  <= pick_idx;
                        code_q     <= build_sel_code(7'(pick_idx));
                        word_cnt_q <= '0;
                        state_q    <= XFER;
                    end else begin
                        code_q  <= NON_FIFO_CHOOSE;
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    if (rd_hit) begin
                        word_cnt_q <= cnt_inc;
                        // An eop on the limit word is a normal release, not a timeout.
                        if (fifo_eop_bits[sel_idx_q] || cnt_inc == MAX_CNT) begin
                            last_grant_q <= sel_idx_q;
                            code_q       <= NON_FIFO_CHOOSE;
                            timeout_q    <= ~fifo_eop_bits[sel_idx_q];
                            state_q      <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_sel_res_final = code_q;
    assign out_valid          = rd_hit;
    assign sched_busy         = (state_q != IDLE);
    assign timeout_err        = timeout_q;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed and random bench for fifo_rr_sched against a cycle-level behavioural model.
module tb_fifo_rr_sched;

    localparam int N    = 14;
    localparam int MAXW = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req, eop;
    logic         rdy;
    logic [N-1:0] rd_en;
    logic [7:0]   code;
    logic         ov, busy, to;

    fifo_rr_sched #(
        .PORT_NUM      (N),
        .MAX_PKT_WORDS (MAXW)
    ) dut (
        .glb_clk            (clk),
        .glb_areset_n       (rst_n),
        .fifo_req_bits      (req),
        .fifo_eop_bits      (eop),
        .out_ready          (rdy),
        .fifo_rd_en         (rd_en),
        .fifo_sel_res_final (code),
        .out_valid          (ov),
        .sched_busy         (busy),
        .timeout_err        (to)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: 0 = idle, 1 = picking, 2 = transferring a packet from m_port.
    int         m_phase, m_port, m_last, m_words;
    logic [7:0] m_code;
    bit         m_to;

    logic [N-1:0] obs_rd;
    logic [7:0]   obs_code;
    logic         obs_to;
    bit           prev_valid;
    int           pop_log[$];
    int           grant_log[$];

    int pops, tos, fc, first_c, base_p, base_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_port = 0; m_last = N - 1; m_words = 0; m_code = 8'd0; m_to = 0;
        prev_valid = 0;
    endtask

    task automatic model_step();
        int w;
        m_to = 0;
        case (m_phase)
            0: if (req != '0) m_phase = 1;
            1: begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
                end
                if (w >= 0) begin
                    m_port = w; m_code = 8'(128 + w); m_words = 0; m_phase = 2;
                end else begin
                    m_code = 8'd0; m_phase = 0;
                end
            end
            default: begin
                if (rdy && req[m_port]) begin
                    m_words++;
                    if (eop[m_port] || m_words == MAXW) begin
                        m_to    = !eop[m_port];
                        m_last  = m_port;
                        m_code  = 8'd0;
                        m_phase = 0;
                    end
                end
            end
        endcase
    endtask

    // Called at a falling edge with inputs applied; checks, then advances one clock.
    task automatic tick();
        logic [N-1:0] exp_rd;
        #1;
        exp_rd = '0;
        if (m_phase == 2 && rdy && req[m_port]) exp_rd[m_port] = 1'b1;
        chk("rd_en", 32'(rd_en), 32'(exp_rd));
        chk("out_valid", 32'(ov), 32'(|exp_rd));
        chk("sel_code", 32'(code), 32'(m_code));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("timeout", 32'(to), 32'(m_to));
        obs_rd = rd_en; obs_code = code; obs_to = to;
        for (int i = 0; i < N; i++) if (rd_en[i]) pop_log.push_back(i);
        if (code[7] && !prev_valid) grant_log.push_back(int'(code[6:0]));
        prev_valid = code[7];
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_pop(input int port);
        bit ok = 0;
        for (int c = 0; c < 12 && !ok; c++) begin
            tick();
            if (obs_rd[port]) ok = 1;
        end
        chk("wait_pop", 32'(ok), 32'd1);
    endtask

    // Requests port (plus others); eop on the nwords-th pop if use_eop; one trailing cycle.
    task automatic run_pkt(input int port, input int nwords, input logic [N-1:0] other,
                           input bit use_eop, output int n_pops, output int n_to,
                           output int code0, output int first_cyc);
        n_pops = 0; n_to = 0; code0 = 0; first_cyc = -1;
        for (int c = 0; c < nwords * 3 + 10 && n_pops < nwords; c++) begin
            req       = other | (N'(1) << port);
            eop       = '0;
            eop[port] = use_eop && (n_pops == nwords - 1);
            tick();
            if (obs_rd[port]) begin
                if (n_pops == 0) begin code0 = int'(obs_code); first_cyc = c; end
                n_pops++;
            end
            if (obs_to) n_to++;
        end
        req = other; eop = '0;
        tick();
        if (obs_to) n_to++;
    endtask

    task automatic wait_grant(input int budget);
        int g0 = grant_log.size();
        for (int c = 0; c < budget && grant_log.size() == g0; c++) tick();
        chk("grant_seen", 32'(grant_log.size() > g0), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; eop = '0; rdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(to), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Fairness: all ports request, every packet one word.
        req = '1; eop = '1; rdy = 1'b1;
        base_p = pop_log.size(); base_g = grant_log.size();
        for (int c = 0; c < 100 && pop_log.size() < base_p + 15; c++) tick();
        chk("fair_budget", 32'(pop_log.size() >= base_p + 15), 32'd1);
        chk("fair_grants", 32'(grant_log.size() - base_g), 32'd15);
        for (int i = 0; i < 15; i++) begin
            if (base_p + i < pop_log.size()) chk("fair_pop", 32'(pop_log[base_p + i]), 32'(i % N));
            if (base_g + i < grant_log.size())
                chk("fair_grant", 32'(grant_log[base_g + i]), 32'(i % N));
        end
        req = '0; eop = '0;
        repeat (3) tick();

        // Single packet on port 2, three words.
        run_pkt(2, 3, '0, 1'b1, pops, tos, fc, first_c);
        chk("sp_pops", 32'(pops), 32'd3);
        chk("sp_code", 32'(fc), 32'd130);
        chk("sp_latency", 32'(first_c), 32'd2);
        chk("sp_code_after", 32'(obs_code), 32'd0);
        chk("sp_timeout", 32'(tos), 32'd0);
        repeat (2) tick();

        // Backpressure on port 7.
        req = N'(1) << 7; eop = '0; rdy = 1'b1;
        wait_pop(7);
        rdy = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_rd_en", 32'(obs_rd), 32'd0);
            chk("bp_code", 32'(obs_code), 32'd135);
        end
        rdy = 1'b1;
        run_pkt(7, 2, '0, 1'b1, pops, tos, fc, first_c);
        chk("bp_rest_pops", 32'(pops), 32'd2);
        chk("bp_resume", 32'(first_c), 32'd0);
        repeat (2) tick();

        // Port 4 goes empty mid-packet while port 5 requests.
        req = N'(1) << 4;
        wait_pop(4);
        req = N'(1) << 5;
        repeat (3) begin
            tick();
            chk("es_rd_en", 32'(obs_rd), 32'd0);
            chk("es_code", 32'(obs_code), 32'd132);
        end
        run_pkt(4, 2, N'(1) << 5, 1'b1, pops, tos, fc, first_c);
        chk("es_rest_pops", 32'(pops), 32'd2);
        base_g = grant_log.size();
        req = N'(1) << 5; eop = N'(1) << 5;
        wait_grant(10);
        if (grant_log.size() > base_g) chk("es_next_grant", 32'(grant_log[base_g]), 32'd5);
        req = '0; eop = '0;
        repeat (4) tick();

        // Watchdog on port 9 (no eop), then port 10 must win over port 9.
        run_pkt(9, MAXW, N'(1) << 10, 1'b0, pops, tos, fc, first_c);
        chk("wd_pops", 32'(pops), 32'(MAXW));
        chk("wd_timeout_pulses", 32'(tos), 32'd1);
        base_g = grant_log.size();
        run_pkt(10, 1, N'(1) << 9, 1'b1, pops, tos, fc, first_c);
        if (grant_log.size() > base_g) chk("wd_next_grant", 32'(grant_log[base_g]), 32'd10);
        else chk("wd_next_grant_seen", 32'd0, 32'd1);
        req = '0;
        repeat (3) tick();
        run_pkt(9, MAXW, '0, 1'b1, pops, tos, fc, first_c);
        chk("wd_eop_pops", 32'(pops), 32'(MAXW));
        chk("wd_eop_no_timeout", 32'(tos), 32'd0);
        repeat (2) tick();

        // Asynchronous reset mid-packet on port 3.
        req = N'(1) << 3; eop = '0; rdy = 1'b1;
        wait_pop(3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rd_en", 32'(rd_en), 32'd0);
        chk("ar_valid", 32'(ov), 32'd0);
        chk("ar_code", 32'(code), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_timeout", 32'(to), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base_g = grant_log.size();
        req = N'(9); eop = N'(9);
        wait_grant(10);
        if (grant_log.size() > base_g) chk("ar_first_grant", 32'(grant_log[base_g]), 32'd0);
        req = '0; eop = '0;
        repeat (4) tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            req = N'($urandom) | N'($urandom);
            eop = N'($urandom) & N'($urandom);
            rdy = ($urandom % 4) != 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
